// File: rtl/sdram_frame_arbiter_pkg.sv
// rtl/sdram_frame_arbiter_pkg.sv - shared types and constants for the SDRAM frame arbiter
package sdram_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } t_arb_state;

  typedef logic [1:0] t_buf_idx;

  // Frame buffers 0..c_num_bufs-1; the slot just past them is the scratch burst area
  localparam int c_num_bufs = 3;

endpackage

// File: rtl/triple_buffer_ctrl.sv
// rtl/triple_buffer_ctrl.sv - triple-buffer index rotation for capture and display
module triple_buffer_ctrl
  import sdram_frame_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_done,
  input  logic       i_rd_swap,
  output logic [1:0] o_wr_idx,
  output logic [1:0] o_rd_idx,
  output logic [1:0] o_latest_idx,
  output logic       o_fresh
);

  t_buf_idx wr_q, wr_d, rd_q, rd_d, latest_q, latest_d;
  logic     fresh_q, fresh_d;

  // Completed capture is published first so a simultaneous display start picks it up
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    latest_d = latest_q;
    fresh_d  = fresh_q;
    if (i_wr_done) begin
      wr_d     = latest_q;
      latest_d = wr_q;
      fresh_d  = 1'b1;
    end
    if (i_rd_swap && fresh_d) begin
      rd_d     = latest_d;
      latest_d = rd_q;
      fresh_d  = 1'b0;
    end
  end

  // Index and freshness registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q     <= 2'd0;
      rd_q     <= 2'd1;
      latest_q <= 2'd2;
      fresh_q  <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      latest_q <= latest_d;
      fresh_q  <= fresh_d;
    end
  end

  assign o_wr_idx     = wr_q;
  assign o_rd_idx     = rd_q;
  assign o_latest_idx = latest_q;
  assign o_fresh      = fresh_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// rtl/sdram_frame_arbiter.sv - burst scheduler between camera/display FIFOs and SDRAM
module sdram_frame_arbiter
  import sdram_frame_arbiter_pkg::*;
#(
  parameter int p_addr_width   = 24,
  parameter int p_burst_len    = 8,
  parameter int p_frame_words  = 307200,
  parameter int p_fifo_depth   = 512,
  parameter int p_levelw       = 10,
  parameter int p_rd_low_water = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_frame_start,
  input  logic                    i_rd_frame_start,
  input  logic [p_levelw-1:0]     i_wr_fifo_level,
  input  logic [p_levelw-1:0]     i_rd_fifo_level,
  output logic                    o_cmd_valid,
  input  logic                    i_cmd_ready,
  output logic                    o_cmd_we,
  output logic [p_addr_width-1:0] o_cmd_addr,
  input  logic                    i_burst_done,
  output logic [1:0]              o_wr_buf,
  output logic [1:0]              o_rd_buf,
  output logic                    o_frame_dropped,
  output logic                    o_busy
);

  localparam logic [p_addr_width-1:0] c_burst   = p_addr_width'(p_burst_len);
  localparam logic [p_addr_width-1:0] c_frame   = p_addr_width'(p_frame_words);
  localparam logic [p_addr_width-1:0] c_scratch = p_addr_width'(c_num_bufs * p_frame_words);

  function automatic logic [p_addr_width-1:0] buf_base(input logic [1:0] idx);
    return p_addr_width'(idx) * c_frame;
  endfunction

  t_arb_state              state_q, state_d;
  logic [p_addr_width-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [p_addr_width-1:0] cmd_addr_q, cmd_addr_d;
  logic                    cmd_we_q, cmd_we_d;
  logic                    rd_active_q, rd_active_d;
  logic                    wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic                    dropped_q, dropped_d;

  logic [p_addr_width-1:0] wr_cnt_eff, rd_cnt_eff, wr_cnt_nxt, rd_cnt_nxt;
  logic                    rd_act_eff;
  logic [1:0]              latest_idx, rd_idx_eff;
  logic                    fresh, wr_done, rd_swap;
  int                      wr_lvl, rd_lvl;

  assign wr_lvl = int'(i_wr_fifo_level);
  assign rd_lvl = int'(i_rd_fifo_level);

  triple_buffer_ctrl u_tbuf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_done    (wr_done),
    .i_rd_swap    (rd_swap),
    .o_wr_idx     (o_wr_buf),
    .o_rd_idx     (o_rd_buf),
    .o_latest_idx (latest_idx),
    .o_fresh      (fresh)
  );

  // A read swap applied in this IDLE cycle lands in the buffer registers next edge,
  // so the read address must already use the post-swap index
  assign rd_idx_eff = (rd_pend_q && fresh) ? latest_idx : o_rd_buf;
  assign wr_cnt_nxt = wr_cnt_q + c_burst;
  assign rd_cnt_nxt = rd_cnt_q + c_burst;

  // Pending frame starts, arbitration, counter advance and next FSM state
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_we_d    = cmd_we_q;
    rd_active_d = rd_active_q;
    wr_pend_d   = wr_pend_q | i_wr_frame_start;
    rd_pend_d   = rd_pend_q | i_rd_frame_start;
    dropped_d   = 1'b0;
    wr_done     = 1'b0;
    rd_swap     = 1'b0;
    wr_cnt_eff  = wr_cnt_q;
    rd_cnt_eff  = rd_cnt_q;
    rd_act_eff  = rd_active_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_pend_q) begin
          if (wr_cnt_q != '0 && wr_cnt_q != c_frame) dropped_d = 1'b1;
          wr_cnt_eff = '0;
        end
        if (rd_pend_q) begin
          rd_cnt_eff = '0;
          rd_act_eff = 1'b1;
          rd_swap    = 1'b1;
        end
        wr_pend_d   = i_wr_frame_start;
        rd_pend_d   = i_rd_frame_start;
        wr_cnt_d    = wr_cnt_eff;
        rd_cnt_d    = rd_cnt_eff;
        rd_active_d = rd_act_eff;
        if (rd_act_eff && rd_lvl < p_rd_low_water) begin
          state_d    = ST_ISSUE;
          cmd_we_d   = 1'b0;
          cmd_addr_d = buf_base(rd_idx_eff) + rd_cnt_eff;
        end else if (wr_lvl >= p_burst_len) begin
          state_d    = ST_ISSUE;
          cmd_we_d   = 1'b1;
          cmd_addr_d = (wr_cnt_eff == c_frame) ? c_scratch : buf_base(o_wr_buf) + wr_cnt_eff;
        end else if (rd_act_eff && (p_fifo_depth - rd_lvl) >= p_burst_len) begin
          state_d    = ST_ISSUE;
          cmd_we_d   = 1'b0;
          cmd_addr_d = buf_base(rd_idx_eff) + rd_cnt_eff;
        end
      end
      ST_ISSUE: begin
        if (i_cmd_ready) begin
          state_d = ST_WAIT;
          if (cmd_we_q) begin
            // Scratch bursts (counter parked at a full frame) do not count
            if (wr_cnt_q != c_frame) begin
              wr_cnt_d = wr_cnt_nxt;
              wr_done  = (wr_cnt_nxt == c_frame);
            end
          end else begin
            rd_cnt_d = rd_cnt_nxt;
            if (rd_cnt_nxt == c_frame) rd_active_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (i_burst_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_we_q    <= 1'b0;
      rd_active_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_we_q    <= cmd_we_d;
      rd_active_q <= rd_active_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      dropped_q   <= dropped_d;
    end
  end

  assign o_cmd_valid     = (state_q == ST_ISSUE);
  assign o_busy          = (state_q != ST_IDLE);
  assign o_cmd_we        = cmd_we_q;
  assign o_cmd_addr      = cmd_addr_q;
  assign o_frame_dropped = dropped_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb/tb_sdram_frame_arbiter.sv - randomized self-checking bench for sdram_frame_arbiter
module tb_sdram_frame_arbiter;

  localparam int F     = 64;
  localparam int B     = 8;
  localparam int DEPTH = 512;
  localparam int LOW   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_fs, rd_fs, cmd_ready, burst_done;
  logic [9:0]  wr_lvl, rd_lvl;
  logic        cmd_valid, cmd_we, dropped, busy;
  logic [23:0] cmd_addr;
  logic [1:0]  wr_buf, rd_buf;

  always #5 clk = ~clk;

  sdram_frame_arbiter #(
    .p_addr_width   (24),
    .p_burst_len    (B),
    .p_frame_words  (F),
    .p_fifo_depth   (DEPTH),
    .p_levelw       (10),
    .p_rd_low_water (LOW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_wr_frame_start (wr_fs),
    .i_rd_frame_start (rd_fs),
    .i_wr_fifo_level  (wr_lvl),
    .i_rd_fifo_level  (rd_lvl),
    .o_cmd_valid      (cmd_valid),
    .i_cmd_ready      (cmd_ready),
    .o_cmd_we         (cmd_we),
    .o_cmd_addr       (cmd_addr),
    .i_burst_done     (burst_done),
    .o_wr_buf         (wr_buf),
    .o_rd_buf         (rd_buf),
    .o_frame_dropped  (dropped),
    .o_busy           (busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int drop_seen = 0;

  always @(posedge clk) begin
    if (rst) drop_seen <= 0;
    else if (dropped) drop_seen <= drop_seen + 1;
  end

  // Reference model: buffer roles, counters and pending frame starts
  int m_wr, m_rd, m_latest, m_wr_cnt, m_rd_cnt, m_drops;
  bit m_fresh, m_rd_active, m_wr_pend, m_rd_pend;

  function automatic void model_reset();
    m_wr = 0; m_rd = 1; m_latest = 2; m_fresh = 0;
    m_wr_cnt = 0; m_rd_cnt = 0; m_rd_active = 0;
    m_wr_pend = 0; m_rd_pend = 0; m_drops = 0;
  endfunction

  function automatic void model_apply_pending();
    int t;
    if (m_wr_pend) begin
      if (m_wr_cnt != 0 && m_wr_cnt != F) m_drops++;
      m_wr_cnt = 0;
      m_wr_pend = 0;
    end
    if (m_rd_pend) begin
      m_rd_cnt = 0;
      m_rd_active = 1;
      if (m_fresh) begin
        t = m_rd; m_rd = m_latest; m_latest = t; m_fresh = 0;
      end
      m_rd_pend = 0;
    end
  endfunction

  function automatic void model_predict(input int wl, input int rl,
                                        output bit c, output bit we, output int a);
    c = 0; we = 0; a = 0;
    if (m_rd_active && rl < LOW) begin c = 1; we = 0; end
    else if (wl >= B) begin c = 1; we = 1; end
    else if (m_rd_active && DEPTH - rl >= B) begin c = 1; we = 0; end
    if (c) a = we ? ((m_wr_cnt == F) ? 3 * F : m_wr * F + m_wr_cnt) : m_rd * F + m_rd_cnt;
  endfunction

  function automatic void model_accept(input bit we);
    int t;
    if (we) begin
      if (m_wr_cnt != F) begin
        m_wr_cnt += B;
        if (m_wr_cnt == F) begin
          t = m_wr; m_wr = m_latest; m_latest = t; m_fresh = 1;
        end
      end
    end else begin
      m_rd_cnt += B;
      if (m_rd_cnt == F) m_rd_active = 0;
    end
  endfunction

  // One arbitration round: levels presented while IDLE, then handshake and completion
  task automatic do_burst(input int wl, input int rl, input int rdy_dly, input int done_dly,
                          input bit pw, input bit pr,
                          output bit got_cmd, output bit got_we, output int got_addr);
    bit e_c, e_we;
    int e_a;
    wr_lvl = 10'(wl);
    rd_lvl = 10'(rl);
    model_predict(wl, rl, e_c, e_we, e_a);
    @(negedge clk);
    got_cmd = cmd_valid; got_we = cmd_we; got_addr = int'(cmd_addr);
    n_total++;
    if (cmd_valid !== e_c) $display("FAIL cmd_valid_rise: got %b want %b (wl=%0d rl=%0d)", cmd_valid, e_c, wl, rl);
    else n_pass++;
    if (!e_c || cmd_valid !== 1'b1) begin
      wr_lvl = 10'd0; rd_lvl = 10'(DEPTH);
      repeat (2) @(negedge clk);
      return;
    end
    n_total++;
    if (cmd_we !== e_we) $display("FAIL cmd_we: got %b want %b", cmd_we, e_we);
    else n_pass++;
    n_total++;
    if (cmd_addr !== 24'(e_a)) $display("FAIL cmd_addr: got %0d want %0d", cmd_addr, e_a);
    else n_pass++;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      n_total++;
      if (cmd_valid !== 1'b1 || cmd_we !== e_we || cmd_addr !== 24'(e_a))
        $display("FAIL cmd_hold: got v=%b we=%b a=%0d want v=1 we=%b a=%0d", cmd_valid, cmd_we, cmd_addr, e_we, e_a);
      else n_pass++;
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    model_accept(e_we);
    n_total++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1) $display("FAIL valid_drop: got v=%b busy=%b want v=0 busy=1", cmd_valid, busy);
    else n_pass++;
    n_total++;
    if (wr_buf !== 2'(m_wr) || rd_buf !== 2'(m_rd))
      $display("FAIL bufs_after_accept: got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_buf, rd_buf, m_wr, m_rd);
    else n_pass++;
    if (pw) begin wr_fs = 1'b1; m_wr_pend = 1; end
    if (pr) begin rd_fs = 1'b1; m_rd_pend = 1; end
    @(negedge clk);
    wr_fs = 1'b0; rd_fs = 1'b0;
    repeat (done_dly) @(negedge clk);
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    wr_lvl = 10'd0; rd_lvl = 10'(DEPTH);
    n_total++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) $display("FAIL idle_gap: got busy=%b v=%b want 0 0", busy, cmd_valid);
    else n_pass++;
    model_apply_pending();
    repeat (2) @(negedge clk);
    n_total++;
    if (drop_seen !== m_drops || wr_buf !== 2'(m_wr) || rd_buf !== 2'(m_rd))
      $display("FAIL post_burst: got drops=%0d wr=%0d rd=%0d want drops=%0d wr=%0d rd=%0d",
               drop_seen, wr_buf, rd_buf, m_drops, m_wr, m_rd);
    else n_pass++;
  endtask

  // Frame-start pulses delivered while the arbiter sits idle on quiet FIFO levels
  task automatic pulse_idle(input bit pw, input bit pr);
    wr_fs = pw; rd_fs = pr;
    if (pw) m_wr_pend = 1;
    if (pr) m_rd_pend = 1;
    @(negedge clk);
    wr_fs = 1'b0; rd_fs = 1'b0;
    model_apply_pending();
    repeat (2) @(negedge clk);
    n_total++;
    if (drop_seen !== m_drops || wr_buf !== 2'(m_wr) || rd_buf !== 2'(m_rd) || busy !== 1'b0)
      $display("FAIL pulse_idle: got drops=%0d wr=%0d rd=%0d busy=%b want drops=%0d wr=%0d rd=%0d busy=0",
               drop_seen, wr_buf, rd_buf, busy, m_drops, m_wr, m_rd);
    else n_pass++;
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1; wr_fs = 1'b0; rd_fs = 1'b0; cmd_ready = 1'b0; burst_done = 1'b0;
    wr_lvl = 10'd0; rd_lvl = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_total++;
    if (cmd_valid !== 1'b0 || cmd_we !== 1'b0 || cmd_addr !== 24'd0 || dropped !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs: got v=%b we=%b a=%0d drop=%b busy=%b want all 0", cmd_valid, cmd_we, cmd_addr, dropped, busy);
    else n_pass++;
    n_total++;
    if (wr_buf !== 2'd0 || rd_buf !== 2'd1) $display("FAIL reset_bufs: got wr=%0d rd=%0d want wr=0 rd=1", wr_buf, rd_buf);
    else n_pass++;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    n_total++;
    if (bad) $display("FAIL reset_no_cmd: got a command with both levels 0 want none");
    else n_pass++;
    rd_lvl = 10'(DEPTH);
  endtask

  task automatic test_capture_frame();
    bit c, we; int a;
    for (int i = 0; i < 8; i++) begin
      do_burst(8, DEPTH, 2, 4, 0, 0, c, we, a);
      n_total++;
      if (c !== 1'b1 || we !== 1'b1 || a !== i * 8) $display("FAIL capture_addr: got c=%b we=%b a=%0d want 1 1 %0d", c, we, a, i * 8);
      else n_pass++;
    end
    n_total++;
    if (wr_buf !== 2'd2) $display("FAIL capture_swap: got wr_buf=%0d want 2", wr_buf);
    else n_pass++;
    do_burst(8, DEPTH, 2, 4, 0, 0, c, we, a);
    n_total++;
    if (a !== 192 || we !== 1'b1) $display("FAIL capture_scratch: got a=%0d we=%b want 192 1", a, we);
    else n_pass++;
  endtask

  task automatic test_read_swap();
    bit c, we; int a;
    pulse_idle(0, 1);
    n_total++;
    if (rd_buf !== 2'd0) $display("FAIL read_swap_buf: got rd_buf=%0d want 0", rd_buf);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      do_burst(0, 100, i % 3, 1, 0, 0, c, we, a);
      n_total++;
      if (c !== 1'b1 || we !== 1'b0 || a !== i * 8) $display("FAIL read_addr: got c=%b we=%b a=%0d want 1 0 %0d", c, we, a, i * 8);
      else n_pass++;
    end
    do_burst(0, 100, 0, 0, 0, 0, c, we, a);
    n_total++;
    if (c !== 1'b0) $display("FAIL read_inactive: got cmd=%b want 0", c);
    else n_pass++;
  endtask

  task automatic test_priority();
    bit c, we; int a;
    pulse_idle(0, 1);
    do_burst(8, 10, 1, 1, 0, 0, c, we, a);
    n_total++;
    if (we !== 1'b0 || a !== 0) $display("FAIL prio_urgent: got we=%b a=%0d want 0 0", we, a);
    else n_pass++;
    do_burst(8, 300, 0, 2, 0, 0, c, we, a);
    n_total++;
    if (we !== 1'b1 || a !== 192) $display("FAIL prio_write: got we=%b a=%0d want 1 192", we, a);
    else n_pass++;
    do_burst(7, 300, 3, 0, 0, 0, c, we, a);
    n_total++;
    if (we !== 1'b0 || a !== 8) $display("FAIL prio_read: got we=%b a=%0d want 0 8", we, a);
    else n_pass++;
  endtask

  task automatic test_drop();
    bit c, we; int a; int d0;
    pulse_idle(1, 0);
    for (int i = 0; i < 3; i++) do_burst(8, DEPTH, 1, 2, 0, 0, c, we, a);
    d0 = drop_seen;
    pulse_idle(1, 0);
    n_total++;
    if (drop_seen !== d0 + 1 || wr_buf !== 2'd2) $display("FAIL drop_pulse: got drops=%0d wr_buf=%0d want %0d 2", drop_seen, wr_buf, d0 + 1);
    else n_pass++;
    do_burst(8, DEPTH, 0, 1, 0, 0, c, we, a);
    n_total++;
    if (a !== 128) $display("FAIL drop_restart: got a=%0d want 128", a);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit c, we; int a;
    for (int i = 0; i < 6; i++) do_burst(8, DEPTH, 0, 1, 0, 0, c, we, a);
    do_burst(8, DEPTH, 1, 3, 0, 1, c, we, a);
    n_total++;
    if (rd_buf !== 2'd2 || wr_buf !== 2'd1) $display("FAIL simul_swap: got rd=%0d wr=%0d want rd=2 wr=1", rd_buf, wr_buf);
    else n_pass++;
    pulse_idle(0, 1);
    n_total++;
    if (rd_buf !== 2'd2) $display("FAIL simul_fresh: got rd=%0d want 2", rd_buf);
    else n_pass++;
  endtask

  task automatic test_random();
    bit c, we; int a;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0)
        pulse_idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_burst($urandom_range(0, 12), $urandom_range(0, 520), $urandom_range(0, 3), $urandom_range(0, 4),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), c, we, a);
    end
  endtask

  task automatic test_mid_reset();
    bit c, we; int a;
    wr_lvl = 10'd8;
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    wr_lvl = 10'd0; rd_lvl = 10'(DEPTH);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_total++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0 || cmd_addr !== 24'd0 || wr_buf !== 2'd0 || rd_buf !== 2'd1)
      $display("FAIL mid_reset: got busy=%b v=%b a=%0d wr=%0d rd=%0d want 0 0 0 0 1", busy, cmd_valid, cmd_addr, wr_buf, rd_buf);
    else n_pass++;
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL stray_done: got busy=%b want 0", busy);
    else n_pass++;
    do_burst(8, DEPTH, 1, 1, 0, 0, c, we, a);
    n_total++;
    if (a !== 0 || we !== 1'b1) $display("FAIL post_reset_addr: got a=%0d we=%b want 0 1", a, we);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_capture_frame();
    test_read_swap();
    test_priority();
    test_drop();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
